// File: rtl/fp_add_sched.sv
// Round-robin scheduler sharing one fixed-latency, non-stallable adder among NREQ requesters.
// A tag pipeline tracks which requester owns each result as it leaves the adder.
module fp_add_sched #(
   parameter int unsigned N    = 16,
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*N-1:0] req_a,
   input  logic [NREQ*N-1:0] req_b,
   output logic [N-1:0]      add_a,
   output logic [N-1:0]      add_b,
   input  logic [N-1:0]      add_result,
   output logic [NREQ-1:0]   resp_valid,
   output logic [N-1:0]      resp_data,
   output logic              busy,
   output logic [15:0]       issue_cnt
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(LAT + 1);

   logic [PW-1:0]  ptr_q, ptr_d;
   logic [LAT-1:0] tag_v_q;
   logic [PW-1:0]  tag_i_q [LAT];
   logic [CW-1:0]  inflight_q, inflight_d;
   logic [15:0]    issue_cnt_q;

   logic           gnt_any;
   logic [PW-1:0]  gnt_idx;
   logic [PW-1:0]  cand;
   logic           resp_due;

   // Ascending search from ptr; the first valid requester found wins.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      req_ready = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = PW'((32'(ptr_q) + k) % NREQ);
         if (en && !gnt_any && req_valid[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
         end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   assign add_a = gnt_any ? req_a[gnt_idx*N +: N] : '0;
   assign add_b = gnt_any ? req_b[gnt_idx*N +: N] : '0;

   assign resp_due = tag_v_q[LAT-1];

   always_comb begin
      resp_valid = '0;
      if (resp_due) resp_valid[tag_i_q[LAT-1]] = 1'b1;
   end

   assign resp_data = resp_due ? add_result : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
   end

   always_comb begin
      inflight_d = inflight_q;
      if (gnt_any && !resp_due)      inflight_d = inflight_q + CW'(1);
      else if (!gnt_any && resp_due) inflight_d = inflight_q - CW'(1);
   end

   // Tags shift every cycle, independent of en, so drained results always surface.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         tag_v_q     <= '0;
         inflight_q  <= '0;
         issue_cnt_q <= '0;
         for (int unsigned i = 0; i < LAT; i++) tag_i_q[i] <= '0;
      end else begin
         ptr_q      <= ptr_d;
         inflight_q <= inflight_d;
         tag_v_q[0] <= gnt_any;
         tag_i_q[0] <= gnt_idx;
         for (int unsigned i = 1; i < LAT; i++) begin
            tag_v_q[i] <= tag_v_q[i-1];
            tag_i_q[i] <= tag_i_q[i-1];
         end
         if (gnt_any) issue_cnt_q <= issue_cnt_q + 16'd1;
      end
   end

   assign busy      = (inflight_q != '0);
   assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_fp_add_sched.sv
// Directed bench for fp_add_sched with a 3-stage behavioural adder sharing rst_n.
module tb_fp_add_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [15:0] add_a;
   logic [15:0] add_b;
   logic [15:0] add_result;
   logic [3:0]  resp_valid;
   logic [15:0] resp_data;
   logic        busy;
   logic [15:0] issue_cnt;

   int n_cmp = 0;
   int n_err = 0;

   fp_add_sched #(.N(16), .NREQ(4), .LAT(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .add_a      (add_a),
      .add_b      (add_b),
      .add_result (add_result),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .busy       (busy),
      .issue_cnt  (issue_cnt)
   );

   always #5 clk = ~clk;

   logic [15:0] ap0, ap1, ap2;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ap0 <= '0;
         ap1 <= '0;
         ap2 <= '0;
      end else begin
         ap0 <= add_a + add_b;
         ap1 <= ap0;
         ap2 <= ap1;
      end
   end
   assign add_result = ap2;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
      req_a[i*16 +: 16] = a;
      req_b[i*16 +: 16] = b;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
      #1;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_issue", 32'(issue_cnt), 0);
      chk("rst_rvalid", 32'(resp_valid), 0);
      chk("rst_rdata", 32'(resp_data), 0);
      chk("rst_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      tick();

      // single op
      en = 1'b1; req_valid = 4'b0001; set_op(0, 16'h0003, 16'h0004);
      #1;
      chk("single_ready", 32'(req_ready), 32'h1);
      chk("single_adda", 32'(add_a), 32'h3);
      chk("single_addb", 32'(add_b), 32'h4);
      chk("single_busy_t", 32'(busy), 0);
      tick(); req_valid = '0; #1;
      chk("single_busy1", 32'(busy), 1);
      chk("single_noresp1", 32'(resp_valid), 0);
      chk("single_idle_adda", 32'(add_a), 0);
      tick();
      chk("single_busy2", 32'(busy), 1);
      tick();
      chk("single_rvalid", 32'(resp_valid), 32'h1);
      chk("single_rdata", 32'(resp_data), 32'h7);
      chk("single_busy3", 32'(busy), 1);
      tick();
      chk("single_rvalid_off", 32'(resp_valid), 0);
      chk("single_rdata_off", 32'(resp_data), 0);
      chk("single_busy4", 32'(busy), 0);
      chk("single_issue", 32'(issue_cnt), 1);

      // round-robin from fresh reset (lowest index first)
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      chk("rr_issue0", 32'(issue_cnt), 0);
      for (int i = 0; i < 4; i++) set_op(i, 16'(16'h0010 * (i + 1)), 16'(i));
      req_valid = 4'b1111;
      for (int k = 0; k < 11; k++) begin
         if (k == 8) req_valid = '0;
         #1;
         if (k < 8) begin
            chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
            chk("rr_adda", 32'(add_a), 32'(16'h0010 * ((k % 4) + 1)));
         end else begin
            chk("rr_ready_idle", 32'(req_ready), 0);
         end
         if (k >= 3) begin
            chk("rr_rvalid", 32'(resp_valid), 32'(1 << ((k - 3) % 4)));
            chk("rr_rdata", 32'(resp_data), 32'(16'h0010 * (((k - 3) % 4) + 1) + ((k - 3) % 4)));
         end else begin
            chk("rr_rvalid_early", 32'(resp_valid), 0);
         end
         tick();
      end
      chk("rr_issue8", 32'(issue_cnt), 8);
      chk("rr_busy_done", 32'(busy), 0);

      // one transfer on requester 1 moves ptr to 2
      req_valid = 4'b0010; #1;
      chk("p1_ready", 32'(req_ready), 32'h2);
      tick(); req_valid = '0;
      tick(); tick();
      chk("p1_rvalid", 32'(resp_valid), 32'h2);
      chk("p1_rdata", 32'(resp_data), 32'h21);
      tick();

      // enable gating with everything pending
      en = 1'b0; req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("en0_ready", 32'(req_ready), 0);
         chk("en0_rvalid", 32'(resp_valid), 0);
         chk("en0_adda", 32'(add_a), 0);
         tick();
      end
      chk("en0_issue", 32'(issue_cnt), 9);
      en = 1'b1; #1;
      chk("en1_ready_ptr", 32'(req_ready), 32'h4);
      tick();
      en = 1'b0; #1;
      chk("endrop_ready", 32'(req_ready), 0);
      tick(); tick();
      chk("endrop_rvalid", 32'(resp_valid), 32'h4);
      chk("endrop_rdata", 32'(resp_data), 32'h32);
      chk("endrop_issue", 32'(issue_cnt), 10);
      req_valid = '0;
      tick();

      // sparse: only requester 2 valid while ptr is 3
      en = 1'b1; req_valid = 4'b0100; set_op(2, 16'h00FF, 16'h0001); #1;
      chk("sparse_ready", 32'(req_ready), 32'h4);
      tick(); req_valid = '0;
      tick(); tick();
      chk("sparse_rvalid", 32'(resp_valid), 32'h4);
      chk("sparse_rdata", 32'(resp_data), 32'h100);
      tick();

      // reset mid-flight discards tags
      req_valid = 4'b0011; set_op(0, 16'h1111, 16'h1); set_op(1, 16'h2222, 16'h2);
      tick(); tick();
      chk("mid_busy_pre", 32'(busy), 1);
      req_valid = '0; rst_n = 1'b0; #1;
      chk("mid_busy_rst", 32'(busy), 0);
      chk("mid_issue_rst", 32'(issue_cnt), 0);
      tick(); rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("mid_rvalid", 32'(resp_valid), 0);
         chk("mid_busy", 32'(busy), 0);
         tick();
      end
      chk("mid_issue", 32'(issue_cnt), 0);

      // issue_cnt wrap
      req_valid = 4'b0001;
      repeat (65535) tick();
      chk("wrap_ffff", 32'(issue_cnt), 32'hFFFF);
      tick(); req_valid = '0;
      chk("wrap_zero", 32'(issue_cnt), 0);
      tick(); tick(); tick(); tick();
      chk("wrap_busy", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
